path_open_set: RTL and testbench
================================

# path_open_set

Sorted-shift-register priority queue holding the A* open set. Sits directly upstream of the A* controller Mealy stage: the controller's node-expansion output pushes candidate nodes, and each pop hands the controller the lowest-f node on the next cycle. Replaces the controller's fixed small open-slot array with a deeper, independently clocked queue.

## Interface
- DEPTH, 16: number of queue slots (≥2).
- CW, 16: coordinate / cost width.
- system1000  in  1  clock, all state on rising edge.
- system1000_rst  in  1  asynchronous reset, active-high.
- clear_i  in  1  synchronous flush of all slots.
- push_valid_i  in  1  push request.
- push_ready_o  out  1  queue can accept a push this cycle.
- push_x_i, push_y_i  in  CW each  node coordinates.
- push_g_i  in  CW  cost from start.
- push_h_i  in  CW  heuristic to goal.
- pop_valid_o  out  1  head entry valid.
- pop_ready_i  in  1  consumer takes head this cycle.
- pop_x_o, pop_y_o, pop_g_o, pop_f_o  out  CW each  head entry fields.
- count_o  out  clog2(DEPTH+1)  occupied slots.

## Operation
- Entry = {valid, f, g, x, y}. Slots 0..DEPTH-1 held sorted by ascending f; valid slots contiguous from slot 0; invalid slots act as f = +infinity.
- f computed on push: f = g + h in CW+1 bits; if bit CW set, f saturates to all-ones (2^CW − 1).
- Push accepted when push_valid_i & push_ready_o. push_ready_o = (count_o < DEPTH) — depends on state only, never on pop_ready_i.
- Pop accepted when pop_valid_o & pop_ready_i. pop_valid_o = slot0.valid; pop_*_o driven directly from slot 0 registers.
- Insert position: first slot k with new f < slot[k].f (strict) — equal keys stay FIFO (older first). Slots ≥k shift up one; last slot's content discarded only if invalid (guaranteed by push_ready).
- Pop only: all slots shift down one; slot DEPTH-1 becomes invalid.
- Push + pop same cycle: popped entry is the current slot 0; new entry inserted among remaining entries (position computed against pre-pop contents, then whole array shifted down); count unchanged. New entry may become new head.
- Push while full with simultaneous pop: refused (push_ready_o low); pop proceeds.
- clear_i: all valid bits cleared, count 0; overrides push/pop that cycle.
- No decrease-key or duplicate merge; duplicate coordinates are queued independently (controller filters on pop).
- Invalid-slot data fields are don't-care but must not reach outputs while pop_valid_o is 0 (outputs forced 0 when invalid).

## Timing
- Reset (async assert, sync release): all slots invalid, data 0; push_ready_o=1, pop_valid_o=0, pop_*_o=0, count_o=0.
- Push latency: entry visible on pop outputs / count_o the cycle after acceptance.
- Pop: next head presented the cycle after acceptance; back-to-back pops every cycle supported.
- Throughput: one push and one pop per cycle sustained.
- Reset mid-operation: contents lost immediately; no partial shift observable after release.
- Critical path: adder + DEPTH parallel comparators + slot mux; no multi-cycle paths.

## Test plan
- Reset then push (x,y,g,h)=(1,2,3,4),(5,6,1,1),(7,8,0,9): pops return f=2,7,9 in that order, count 3→0, pop_valid_o low after third pop.
- Push f=5 three times with x=10,11,12 (g=5,h=0): pops return x=10,11,12 (FIFO ties).
- Fill DEPTH=16 entries: push_ready_o low, count 16; push_valid_i held with pop_ready_i high: push refused, count 15, then next cycle push accepted, count 16.
- Queue holds f=4,8; same-cycle push f=2 and pop: popped f=4, next head f=2, count 2.
- Push g=0xFFF0,h=0x0020: pop_f_o=0xFFFF; push g=0xFFF0,h=0x000F: pop_f_o=0xFFFF, ordered after first (tie FIFO).
- With 5 entries, assert clear_i concurrently with push: count 0, pop_valid_o 0 next cycle; assert system1000_rst mid-stream: outputs return to reset values immediately.

Source files
------------

// File: rtl/path_open_set.sv
// A* open set: sorted shift-register priority queue, lowest f at slot 0.
// Each slot picks its next value from itself, a neighbour, or the new entry.

module path_open_set_slot #(
  parameter int EW = 65
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_psh,
  input  logic          i_pop,
  input  logic          i_lt_dn,
  input  logic          i_lt_here,
  input  logic          i_lt_up,
  input  logic [EW-1:0] i_dn,
  input  logic [EW-1:0] i_up,
  input  logic [EW-1:0] i_nw,
  output logic [EW-1:0] o_q
);
  // i_lt_* are "new entry sorts before this slot" flags; they are monotonic
  // along the array, so the insert point is where the flag first rises.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_q <= '0;
    else if (i_clr) o_q <= '0;
    else begin
      unique case ({i_psh, i_pop})
        2'b10: if (i_lt_here) o_q <= i_lt_dn ? i_dn : i_nw;
        2'b01: o_q <= i_up;
        2'b11: begin
          // insert into the pre-pop array, then shift everything down one
          if (!i_lt_up) o_q <= i_up;
          else if (!i_lt_here) o_q <= i_nw;
        end
        default: ;
      endcase
    end
  end
endmodule

module path_open_set #(
  parameter int DEPTH = 16,
  parameter int CW    = 16,
  localparam int CNTW = $clog2(DEPTH+1)
) (
  input  logic            system1000,
  input  logic            system1000_rst,
  input  logic            clear_i,
  input  logic            push_valid_i,
  output logic            push_ready_o,
  input  logic [CW-1:0]   push_x_i,
  input  logic [CW-1:0]   push_y_i,
  input  logic [CW-1:0]   push_g_i,
  input  logic [CW-1:0]   push_h_i,
  output logic            pop_valid_o,
  input  logic            pop_ready_i,
  output logic [CW-1:0]   pop_x_o,
  output logic [CW-1:0]   pop_y_o,
  output logic [CW-1:0]   pop_g_o,
  output logic [CW-1:0]   pop_f_o,
  output logic [CNTW-1:0] count_o
);
  // entry = {vld, f, g, x, y}
  localparam int EW = 4*CW + 1;
  localparam logic [CNTW-1:0] FULL = CNTW'(DEPTH);

  logic [DEPTH-1:0][EW-1:0] w_slot, w_dn, w_up;
  logic [DEPTH-1:0]         w_lt, w_ltdn, w_ltup, w_lthere;
  logic [DEPTH:0]           w_lte;
  logic [CW:0]              w_sum;
  logic [CW-1:0]            w_f;
  logic [EW-1:0]            w_nw;
  logic                     w_rdy, w_hv, w_psh, w_pop;
  logic [CNTW-1:0]          r_cnt;

  assign w_sum = {1'b0, push_g_i} + {1'b0, push_h_i};
  assign w_f   = w_sum[CW] ? {CW{1'b1}} : w_sum[CW-1:0];
  assign w_nw  = {1'b1, w_f, push_g_i, push_x_i, push_y_i};

  assign w_rdy = (r_cnt < FULL);
  assign w_hv  = w_slot[0][EW-1];
  assign w_psh = push_valid_i & w_rdy;
  assign w_pop = pop_ready_i & w_hv;

  // On push+pop the head is leaving, so the new entry may not land in slot 0
  // of the pre-pop array; the region past the last slot counts as +infinity.
  assign w_lte    = {1'b1, w_lt[DEPTH-1:1], w_lt[0] & ~w_pop};
  assign w_lthere = w_lte[DEPTH-1:0];
  assign w_ltdn   = {w_lte[DEPTH-2:0], 1'b0};
  assign w_ltup   = w_lte[DEPTH:1];
  assign w_dn     = {w_slot[DEPTH-2:0], {EW{1'b0}}};
  assign w_up     = {{EW{1'b0}}, w_slot[DEPTH-1:1]};

  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    assign w_lt[k] = ~w_slot[k][EW-1] | (w_f < w_slot[k][4*CW-1 -: CW]);

    path_open_set_slot #(.EW(EW)) u_slot (
      .i_clk     (system1000),
      .i_rst     (system1000_rst),
      .i_clr     (clear_i),
      .i_psh     (w_psh),
      .i_pop     (w_pop),
      .i_lt_dn   (w_ltdn[k]),
      .i_lt_here (w_lthere[k]),
      .i_lt_up   (w_ltup[k]),
      .i_dn      (w_dn[k]),
      .i_up      (w_up[k]),
      .i_nw      (w_nw),
      .o_q       (w_slot[k])
    );
  end

  always_ff @(posedge system1000 or posedge system1000_rst) begin
    if (system1000_rst) r_cnt <= '0;
    else if (clear_i) r_cnt <= '0;
    else if (w_psh && !w_pop) r_cnt <= r_cnt + 1'b1;
    else if (w_pop && !w_psh) r_cnt <= r_cnt - 1'b1;
  end

  assign push_ready_o = w_rdy;
  assign pop_valid_o  = w_hv;
  assign count_o      = r_cnt;
  assign pop_f_o      = w_slot[0][4*CW-1 -: CW] & {CW{w_hv}};
  assign pop_g_o      = w_slot[0][3*CW-1 -: CW] & {CW{w_hv}};
  assign pop_x_o      = w_slot[0][2*CW-1 -: CW] & {CW{w_hv}};
  assign pop_y_o      = w_slot[0][CW-1:0]       & {CW{w_hv}};
endmodule

// File: tb/tb_path_open_set.sv
// Bench for path_open_set: directed scenarios plus random traffic against a
// queue-based reference of the open set.
module tb_path_open_set;
  localparam int DEPTH = 16;
  localparam int CW    = 16;
  localparam int CNTW  = $clog2(DEPTH+1);

  logic            clk = 1'b0;
  logic            rst, clr, pv, pr;
  logic [CW-1:0]   px, py, pg, ph;
  logic            prdy, popv;
  logic [CW-1:0]   ox, oy, og, of;
  logic [CNTW-1:0] cnt;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [CW-1:0] x, y, g, f;
  } ent_t;
  ent_t q[$];

  always #5 clk = ~clk;

  path_open_set #(.DEPTH(DEPTH), .CW(CW)) dut (
    .system1000     (clk),
    .system1000_rst (rst),
    .clear_i        (clr),
    .push_valid_i   (pv),
    .push_ready_o   (prdy),
    .push_x_i       (px),
    .push_y_i       (py),
    .push_g_i       (pg),
    .push_h_i       (ph),
    .pop_valid_o    (popv),
    .pop_ready_i    (pr),
    .pop_x_o        (ox),
    .pop_y_o        (oy),
    .pop_g_o        (og),
    .pop_f_o        (of),
    .count_o        (cnt)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] fsat(input logic [CW-1:0] g, input logic [CW-1:0] h);
    longint s;
    s = longint'(g) + longint'(h);
    return (s > (longint'(1) << CW) - 1) ? {CW{1'b1}} : CW'(s);
  endfunction

  task automatic check_outs();
    chk("count", 64'(cnt), 64'(q.size()));
    chk("push_ready", 64'(prdy), 64'(q.size() < DEPTH));
    chk("pop_valid", 64'(popv), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk("head_x", 64'(ox), 64'(q[0].x));
      chk("head_y", 64'(oy), 64'(q[0].y));
      chk("head_g", 64'(og), 64'(q[0].g));
      chk("head_f", 64'(of), 64'(q[0].f));
    end else begin
      chk("empty_data", {ox, oy, og, of}, 64'd0);
    end
  endtask

  // Called just after a falling edge: check, drive, advance the model, clock.
  task automatic cyc(input logic c, input logic v, input logic r,
                     input logic [CW-1:0] x, input logic [CW-1:0] y,
                     input logic [CW-1:0] g, input logic [CW-1:0] h);
    bit   do_push, do_pop;
    int   idx;
    ent_t e;
    check_outs();
    clr = c; pv = v; pr = r; px = x; py = y; pg = g; ph = h;
    if (c) q.delete();
    else begin
      do_push = v && (q.size() < DEPTH);
      do_pop  = r && (q.size() != 0);
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        e.x = x; e.y = y; e.g = g; e.f = fsat(g, h);
        idx = q.size();
        for (int i = q.size() - 1; i >= 0; i--)
          if (e.f < q[i].f) idx = i;
        q.insert(idx, e);
      end
    end
    @(posedge clk);
    @(negedge clk);
    clr = 0; pv = 0; pr = 0;
  endtask

  task automatic push(input logic [CW-1:0] x, input logic [CW-1:0] y,
                      input logic [CW-1:0] g, input logic [CW-1:0] h);
    cyc(0, 1, 0, x, y, g, h);
  endtask

  task automatic pop();
    cyc(0, 0, 1, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; clr = 0; pv = 0; pr = 0; px = 0; py = 0; pg = 0; ph = 0;
    #7;
    chk("rst_outs", {48'd0, ox, oy, og, of} | 64'(popv), 64'd0);
    chk("rst_cnt", 64'(cnt), 64'd0);
    chk("rst_ready", 64'(prdy), 64'd1);
    @(negedge clk);
    rst = 0;
    @(negedge clk);

    // basic ordering
    push(1, 2, 3, 4); push(5, 6, 1, 1); push(7, 8, 0, 9);
    chk("t1_cnt", 64'(cnt), 64'd3);
    chk("t1_f0", 64'(of), 64'd2);
    pop();
    chk("t1_f1", 64'(of), 64'd7);
    pop();
    chk("t1_f2", 64'(of), 64'd9);
    pop();
    chk("t1_empty", 64'(popv), 64'd0);

    // FIFO among equal keys
    for (int i = 10; i <= 12; i++) push(CW'(i), 0, 5, 0);
    for (int i = 10; i <= 12; i++) begin
      chk("t2_tie_x", 64'(ox), 64'(i));
      pop();
    end

    // full queue, push refused while popping
    for (int i = 0; i < DEPTH; i++) push(CW'(i), CW'(i), CW'($urandom_range(0, 20)), 0);
    chk("t3_full_rdy", 64'(prdy), 64'd0);
    chk("t3_full_cnt", 64'(cnt), 64'd16);
    cyc(0, 1, 1, 99, 99, 1, 1);
    chk("t3_refused_cnt", 64'(cnt), 64'd15);
    cyc(0, 1, 0, 99, 99, 1, 1);
    chk("t3_accept_cnt", 64'(cnt), 64'd16);
    cyc(1, 0, 0, 0, 0, 0, 0);

    // push+pop with new entry becoming head
    push(1, 1, 4, 0); push(2, 2, 8, 0);
    chk("t4_head_before", 64'(of), 64'd4);
    cyc(0, 1, 1, 3, 3, 2, 0);
    chk("t4_head_after", 64'(of), 64'd2);
    chk("t4_cnt", 64'(cnt), 64'd2);
    cyc(1, 0, 0, 0, 0, 0, 0);

    // saturation and tie with saturated key
    push(1, 0, 16'hFFF0, 16'h0020); push(2, 0, 16'hFFF0, 16'h000F);
    chk("t5_sat_f", 64'(of), 64'hFFFF);
    chk("t5_sat_x", 64'(ox), 64'd1);
    pop();
    chk("t5_sat2_f", 64'(of), 64'hFFFF);
    chk("t5_sat2_x", 64'(ox), 64'd2);
    pop();

    // clear overrides push
    for (int i = 0; i < 5; i++) push(CW'(i), 0, CW'(i), 1);
    cyc(1, 1, 1, 7, 7, 7, 7);
    chk("t6_clr_cnt", 64'(cnt), 64'd0);
    chk("t6_clr_vld", 64'(popv), 64'd0);

    // async reset mid-stream
    for (int i = 0; i < 3; i++) push(CW'(i + 1), 0, CW'(i + 1), 0);
    #2 rst = 1;
    #1;
    chk("t6_rst_cnt", 64'(cnt), 64'd0);
    chk("t6_rst_vld", 64'(popv), 64'd0);
    chk("t6_rst_data", {ox, oy, og, of}, 64'd0);
    q.delete();
    @(negedge clk);
    rst = 0;
    @(negedge clk);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [CW-1:0] g, h;
      if ($urandom_range(0, 3) == 0) begin
        g = CW'($urandom); h = CW'($urandom);
      end else begin
        g = CW'($urandom_range(0, 7)); h = CW'($urandom_range(0, 3));
      end
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 99) < 60,
          $urandom_range(0, 99) < 45, CW'($urandom), CW'($urandom), g, h);
    end
    check_outs();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
